lsu_ctrl: RTL and testbench

- Load/store sequencer directly upstream of the byte-lane data-memory bridge.
- Accepts one RV32 load/store per handshake from the MEM pipeline stage.
- Validates the request, then drives re/we/width/addr/wdata strobes to the bridge for a fixed number of cycles.
- Captures returned data, sign/zero-extends it, and returns a single-cycle response with an error flag.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_load_ext.sv | 22 ++
 rtl/lsu_ctrl.sv | 135 +++++++++++++
 tb/tb_lsu_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, bridge width encodings and FSM states for lsu_ctrl
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // Stores only know B/H/W; loads additionally have the unsigned B/H forms.
   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!we) begin
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// rtl/lsu_load_ext.sv - sign/zero extension of right-aligned load data by funct3
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_data,
   output logic [31:0] o_data
);

   // Select the extension rule from the load type; word passes through.
   always_comb begin
      o_data = i_data;
      case (i_funct3)
         F3_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
         F3_BU:   o_data = {24'd0, i_data[7:0]};
         F3_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
         F3_HU:   o_data = {16'd0, i_data[15:0]};
         default: o_data = i_data;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32 load/store sequencer driving the byte-lane memory bridge (option: LSU_MISALIGN_TRAP_EN)
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int MEM_LAT = 1
)(
   input  logic        i_clk,
   input  logic        i_rst,          // active low
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic        o_mem_re,
   output logic        o_mem_we,
   output logic [1:0]  o_mem_width,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   localparam logic [2:0] LAT = 3'(MEM_LAT);

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic        r_we;
   logic [2:0]  r_funct3;

   logic [1:0]  w_size_m1;
   logic [32:0] w_last;
   logic        w_fault;
   logic        w_misalign;
   logic        w_err;
   logic [31:0] w_ext;

   // Bytes touched minus one; the fault check looks at the last byte so a
   // word straddling the top of memory is caught.
   always_comb begin
      w_size_m1 = 2'd0;
      case (i_req_funct3[1:0])
         W_BYTE:  w_size_m1 = 2'd0;
         W_HALF:  w_size_m1 = 2'd1;
         default: w_size_m1 = 2'd3;
      endcase
   end

   assign w_last  = {1'b0, i_req_addr} + {31'd0, w_size_m1};
   assign w_fault = (w_last >> ADDR_W) != 33'd0;

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misalign = ((i_req_funct3[1:0] == W_HALF) && i_req_addr[0]) ||
                       ((i_req_funct3[1:0] == W_WORD) && (i_req_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_err = !funct3_legal(i_req_we, i_req_funct3) || w_fault || w_misalign;

   lsu_load_ext u_ext (
      .i_funct3 (r_funct3),
      .i_data   (i_mem_rdata),
      .o_data   (w_ext)
   );

   // Sequencer: accept, hold strobes for MEM_LAT+1 cycles, then one response cycle.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 3'd0;
         r_we         <= 1'b0;
         r_funct3     <= 3'd0;
         o_req_ready  <= 1'b1;
         o_resp_valid <= 1'b0;
         o_resp_err   <= 1'b0;
         o_resp_rdata <= 32'd0;
         o_mem_re     <= 1'b0;
         o_mem_we     <= 1'b0;
         o_mem_width  <= W_BYTE;
         o_mem_addr   <= 32'd0;
         o_mem_wdata  <= 32'd0;
      end else begin
         o_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req_valid && o_req_ready) begin
                  o_req_ready <= 1'b0;
                  r_we        <= i_req_we;
                  r_funct3    <= i_req_funct3;
                  if (w_err) begin
                     // Rejected requests never touch the bridge.
                     r_state      <= S_DONE;
                     o_resp_valid <= 1'b1;
                     o_resp_err   <= 1'b1;
                     o_resp_rdata <= 32'd0;
                  end else begin
                     r_state     <= S_ACCESS;
                     r_cnt       <= 3'd0;
                     o_mem_re    <= ~i_req_we;
                     o_mem_we    <= i_req_we;
                     o_mem_width <= i_req_funct3[1:0];
                     o_mem_addr  <= i_req_addr;
                     o_mem_wdata <= i_req_wdata;
                  end
               end
            end
            S_ACCESS: begin
               if (r_cnt == LAT) begin
                  r_state      <= S_DONE;
                  o_mem_re     <= 1'b0;
                  o_mem_we     <= 1'b0;
                  o_resp_valid <= 1'b1;
                  o_resp_err   <= 1'b0;
                  o_resp_rdata <= r_we ? 32'd0 : w_ext;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               o_req_ready <= 1'b1;
            end
            default: begin
               r_state     <= S_IDLE;
               o_req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl: directed cases plus randomized ops against a timeline model
module tb_lsu_ctrl;

   localparam int AW  = 6;
   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_re;
   logic        mem_we;
   logic [1:0]  mem_width;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;

   int n_checks = 0;
   int n_pass   = 0;
   bit rand_rdata = 1'b0;

   lsu_ctrl #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_funct3 (req_funct3),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_resp_valid (resp_valid),
      .o_resp_rdata (resp_rdata),
      .o_resp_err   (resp_err),
      .o_mem_re     (mem_re),
      .o_mem_we     (mem_we),
      .o_mem_width  (mem_width),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] d);
      int v;
      case (f3)
         3'b000: begin v = int'(d & 32'hFF);   if (v >= 128)   v = v - 256;   end
         3'b100: v = int'(d & 32'hFF);
         3'b001: begin v = int'(d & 32'hFFFF); if (v >= 32768) v = v - 65536; end
         3'b101: v = int'(d & 32'hFFFF);
         default: v = int'(d);
      endcase
      return 32'(v);
   endfunction

   function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
      bit     legal;
      longint size;
      longint last;
      if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      if (!legal) return 1'b1;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      last = longint'({32'd0, a}) + size - 1;
      if (last >= (longint'(1) << AW)) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((longint'({32'd0, a}) % size) != 0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Model state: the op in flight and how many cycles have passed since acceptance.
   bit          m_busy = 1'b0;
   int          m_age  = 0;
   bit          m_err  = 1'b0;
   bit          m_we   = 1'b0;
   logic [2:0]  m_f3   = 3'd0;
   logic [31:0] m_addr = 32'd0;
   logic [31:0] m_wdata = 32'd0;
   logic [31:0] m_rdata = 32'd0;
   int          m_acc  = 0;
   bit          m_was_idle;

   // Advance the model timeline at each clock edge (reset clears it at once).
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy  = 1'b0;
         m_age   = 0;
         m_rdata = 32'd0;
      end else begin
         m_was_idle = !m_busy;
         if (m_busy) begin
            if (!m_err && m_age == LAT + 1)
               m_rdata = m_we ? 32'd0 : model_ext(m_f3, mem_rdata);
            m_age++;
            if (m_age > (m_err ? 1 : LAT + 2)) m_busy = 1'b0;
         end
         if (m_was_idle && req_valid) begin
            m_busy  = 1'b1;
            m_age   = 1;
            m_we    = req_we;
            m_f3    = req_funct3;
            m_addr  = req_addr;
            m_wdata = req_wdata;
            m_err   = model_err(req_we, req_funct3, req_addr);
            if (m_err) m_rdata = 32'd0;
            m_acc++;
         end
      end
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      bit strobe;
      bit resp;
      strobe = m_busy && !m_err && (m_age <= LAT + 1);
      resp   = m_busy && (m_age == (m_err ? 1 : LAT + 2));
      chk("m_req_ready", 32'(req_ready), 32'(!m_busy));
      chk("m_mem_re", 32'(mem_re), 32'(strobe && !m_we));
      chk("m_mem_we", 32'(mem_we), 32'(strobe && m_we));
      chk("m_resp_valid", 32'(resp_valid), 32'(resp));
      chk("m_resp_rdata", resp_rdata, m_rdata);
      if (strobe) begin
         chk("m_mem_width", 32'(mem_width), 32'(m_f3[1:0]));
         chk("m_mem_addr", mem_addr, m_addr);
         if (m_we) chk("m_mem_wdata", mem_wdata, m_wdata);
      end
      if (resp) chk("m_resp_err", 32'(resp_err), 32'(m_err));
   end

   always @(negedge clk) begin
      if (rand_rdata) mem_rdata = $urandom;
   end

   // ---------------- directed helpers ----------------
   task automatic wait_idle();
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("idle_timeout", 32'(req_ready), 32'd1);
   endtask

   task automatic dir_op(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd);
      int ns;
      wait_idle();
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      ns = exp_err ? 0 : LAT + 1;
      for (int k = 0; k < ns; k++) begin
         chk({nm, "_re"}, 32'(mem_re), 32'(!we));
         chk({nm, "_we"}, 32'(mem_we), 32'(we));
         chk({nm, "_width"}, 32'(mem_width), 32'(f3[1:0]));
         chk({nm, "_addr"}, mem_addr, a);
         if (we) chk({nm, "_wdata"}, mem_wdata, wd);
         @(negedge clk);
      end
      chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, "_resp_err"}, 32'(resp_err), 32'(exp_err));
      chk({nm, "_resp_rdata"}, resp_rdata, exp_rd);
      chk({nm, "_no_strobe"}, 32'(mem_re | mem_we), 32'd0);
      @(negedge clk);
      chk({nm, "_resp_drop"}, 32'(resp_valid), 32'd0);
      chk({nm, "_rdata_hold"}, resp_rdata, exp_rd);
   endtask

   task automatic rand_issue();
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      int          start;
      bit          got;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
         case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
         endcase
      end
      case ($urandom_range(0, 9))
         0: a = 32'h40 + 32'($urandom_range(0, 15));
         1: a = $urandom;
         2: a = 32'(64 - $urandom_range(1, 4));
         default: a = 32'($urandom_range(0, 63));
      endcase
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = $urandom; req_valid = 1'b1;
      start = m_acc;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (m_acc != start) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("accept_timeout", 32'(got), 32'd1);
      req_valid = 1'b0;
      req_we = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom_range(0, 7));
      req_addr = $urandom; req_wdata = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_width", 32'(mem_width), 32'd0);
      chk("rst_strobes", 32'(mem_re | mem_we), 32'd0);
      #2 rst = 1'b1;
      @(negedge clk);

      mem_rdata = 32'hDEADBEEF;
      dir_op("lw", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
      mem_rdata = 32'h12345680;
      dir_op("lb", 1'b0, 3'b000, 32'h21, 32'd0, 1'b0, 32'hFFFFFF80);
      dir_op("lbu", 1'b0, 3'b100, 32'h21, 32'd0, 1'b0, 32'h00000080);
      mem_rdata = 32'h0000F00D;
      dir_op("lh", 1'b0, 3'b001, 32'h08, 32'd0, 1'b0, 32'hFFFFF00D);
      dir_op("lhu", 1'b0, 3'b101, 32'h08, 32'd0, 1'b0, 32'h0000F00D);
      dir_op("sh", 1'b1, 3'b001, 32'h04, 32'h1234ABCD, 1'b0, 32'd0);
      dir_op("fault", 1'b0, 3'b010, 32'h40, 32'd0, 1'b1, 32'd0);
      dir_op("f3bad", 1'b0, 3'b011, 32'h00, 32'd0, 1'b1, 32'd0);
      dir_op("sbad", 1'b1, 3'b100, 32'h00, 32'd0, 1'b1, 32'd0);
      dir_op("lw_top", 1'b0, 3'b010, 32'h3E, 32'd0, 1'b1, 32'd0);
      dir_op("lb_top", 1'b0, 3'b000, 32'h3F, 32'd0, 1'b0, 32'h0000000D);
      mem_rdata = 32'hCAFEF00D;
`ifdef LSU_MISALIGN_TRAP_EN
      dir_op("lw_mis", 1'b0, 3'b010, 32'h02, 32'd0, 1'b1, 32'd0);
`else
      dir_op("lw_mis", 1'b0, 3'b010, 32'h02, 32'd0, 1'b0, 32'hCAFEF00D);
`endif

      // Reset pulsed during the first ACCESS cycle.
      wait_idle();
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0C; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_re_before", 32'(mem_re), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("abort_re", 32'(mem_re), 32'd0);
      chk("abort_we", 32'(mem_we), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      chk("abort_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_resp", 32'(resp_valid), 32'd0);
         chk("abort_ready_after", 32'(req_ready), 32'd1);
      end

      rand_rdata = 1'b1;
      for (int i = 0; i < 400; i++) rand_issue();
      repeat (8) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
